add_share_ctrl: RTL

Time-shares one registered 4-bit adder (`add`, sum registered one clock after a/b) among NUM_REQ requesters. Uses a round-robin grant and a small FSM to do three things: accept one operand pair, drive it onto the adder, and return the sum to the granted requester as a one-cycle pulse. Sits between requester logic and the `add` instance. The adder ports connect through the add_if signal set (a, b, sum, clk).

---
 rtl/add_share_ctrl_pkg.sv | 19 +
 rtl/add_share_ctrl_if.sv | 24 ++
 rtl/add_share_ctrl_rr_pick.sv | 34 +++
 rtl/add_share_ctrl.sv | 106 ++++++++++
 4 files changed

// File: rtl/add_share_ctrl_pkg.sv
// Shared types and defaults for the time-shared adder controller.
package add_share_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_e;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DW      = 4;

    // Pointer/index width; a single requester still needs a 1-bit field.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/add_share_ctrl_if.sv
// Requester-side bus of add_share_ctrl: operand request and result pulse.
// An operand pair transfers on the rising edge where req_valid[i] && req_ready[i];
// resp_valid is a one-cycle pulse with no backpressure, resp_sum valid alongside it.
interface add_share_ctrl_if #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*DW-1:0] req_a;
    logic [NUM_REQ*DW-1:0] req_b;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [DW:0]           resp_sum;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, resp_valid, resp_sum
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, resp_valid, resp_sum
    );
endinterface

// File: rtl/add_share_ctrl_rr_pick.sv
// Round-robin picker: first valid requester at or after ptr, wrapping at NUM_REQ.
module rr_pick
    import add_share_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [ptr_w(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]        gnt_oh,
    output logic [ptr_w(NUM_REQ)-1:0] gnt_idx,
    output logic                      any_valid
);
    localparam int PW = ptr_w(NUM_REQ);

    logic [PW:0] j;

    always_comb begin
        gnt_oh    = '0;
        gnt_idx   = '0;
        any_valid = 1'b0;
        j         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = {1'b0, ptr} + (PW+1)'(k);
            if (j >= (PW+1)'(NUM_REQ)) begin
                j = j - (PW+1)'(NUM_REQ);
            end
            if (!any_valid && req_valid[j[PW-1:0]]) begin
                any_valid            = 1'b1;
                gnt_oh[j[PW-1:0]]    = 1'b1;
                gnt_idx              = j[PW-1:0];
            end
        end
    end
endmodule

// File: rtl/add_share_ctrl.sv
// Shares one registered adder among NUM_REQ requesters: accept, issue, capture, respond.
module add_share_ctrl
    import add_share_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DW      = DEF_DW
) (
    input  logic                      clk,
    input  logic                      rst_n,
    add_share_ctrl_if.slave           bus,
    output logic [DW-1:0]             add_a,
    output logic [DW-1:0]             add_b,
    input  logic [DW:0]               add_sum,
    output logic                      busy,
    output state_e                    dbg_state,
    output logic [ptr_w(NUM_REQ)-1:0] dbg_ptr
);
    localparam int PW = ptr_w(NUM_REQ);

    state_e             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      gnt_q, gnt_d;
    logic [DW-1:0]      add_a_q, add_a_d;
    logic [DW-1:0]      add_b_q, add_b_d;
    logic [DW:0]        resp_sum_q, resp_sum_d;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic               busy_q, busy_d;

    logic [NUM_REQ-1:0] pick_oh;
    logic [PW-1:0]      pick_idx;
    logic               pick_any;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_valid (bus.req_valid),
        .ptr       (ptr_q),
        .gnt_oh    (pick_oh),
        .gnt_idx   (pick_idx),
        .any_valid (pick_any)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        add_a_d      = add_a_q;
        add_b_d      = add_b_q;
        resp_sum_d   = resp_sum_q;
        resp_valid_d = '0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (pick_idx == PW'(i)) begin
                            add_a_d = bus.req_a[i*DW +: DW];
                            add_b_d = bus.req_b[i*DW +: DW];
                        end
                    end
                    gnt_d   = pick_idx;
                    ptr_d   = (pick_idx == PW'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE:   state_d = CAPTURE;
            // The adder registered add_a+add_b at the end of ISSUE.
            CAPTURE: begin
                resp_sum_d          = add_sum;
                resp_valid_d[gnt_q] = 1'b1;
                state_d             = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            gnt_q        <= '0;
            add_a_q      <= '0;
            add_b_q      <= '0;
            resp_sum_q   <= '0;
            resp_valid_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
            resp_sum_q   <= resp_sum_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE) ? pick_oh : '0;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_sum   = resp_sum_q;
    assign add_a          = add_a_q;
    assign add_b          = add_b_q;
    assign busy           = busy_q;
    assign dbg_state      = state_q;
    assign dbg_ptr        = ptr_q;
endmodule
